// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width/parity/stop bits, synchronised input,
// 3-sample majority voting, false-start rejection, error flags and a valid/ready output register.
module uart_rx_cfg #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 bit_in,
    input  logic                 ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);
    localparam int unsigned BitW = 4;
    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] CntMidLo = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] CntMid = CntW'(OVERSAMPLE / 2);
    localparam logic [CntW-1:0] CntMidHi = CntW'(OVERSAMPLE / 2 + 1);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop, StBrk} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ln, ln_prev_q;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic                   s0_q, s1_q;
    logic                   vote, at_mid, at_end, par_expect, done;

    assign ln         = sync_q[SYNC_STAGES-1];
    assign vote       = (s0_q & s1_q) | (s0_q & ln) | (s1_q & ln);
    assign at_mid     = (cnt_q == CntMidHi);
    assign at_end     = (cnt_q == CntLast);
    assign par_expect = (PARITY == 2) ? ^shreg_q : ~^shreg_q;
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bit_in};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        done    = 1'b0;
        if (baud_tick) begin
            cnt_d = cnt_q + CntW'(1);
            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    if (ln_prev_q && !ln) begin
                        state_d = StStart;
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                StStart: begin
                    if (at_mid && vote) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (at_end) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
                StData: begin
                    if (at_mid) shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    if (at_end) begin
                        cnt_d = '0;
                        if (bit_q == LastData) begin
                            bit_d   = '0;
                            state_d = (PARITY != 0) ? StPar : StStop;
                        end else begin
                            bit_d = bit_q + BitW'(1);
                        end
                    end
                end
                StPar: begin
                    if (at_mid) perr_d = vote ^ par_expect;
                    if (at_end) begin
                        state_d = StStop;
                        cnt_d   = '0;
                    end
                end
                StStop: begin
                    if (at_mid) begin
                        if (!vote) ferr_d = 1'b1;
                        // Finish mid-stop so the next start edge can be caught half a bit early.
                        if (bit_q == LastStop) begin
                            done    = 1'b1;
                            state_d = ferr_d ? StBrk : StIdle;
                            cnt_d   = '0;
                            bit_d   = '0;
                        end
                    end else if (at_end) begin
                        cnt_d = '0;
                        bit_d = bit_q + BitW'(1);
                    end
                end
                StBrk: begin
                    cnt_d = '0;
                    if (ln) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            ln_prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            if (baud_tick) begin
                ln_prev_q <= ln;
                if (cnt_q == CntMidLo) s0_q <= ln;
                if (cnt_q == CntMid) s1_q <= ln;
            end
        end
    end

    // Output register: a completion always wins over a handshake in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (done) begin
            data_out   <= shreg_q;
            parity_err <= perr_q;
            frame_err  <= ferr_d;
            overrun    <= valid & ~ready;
            valid      <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: an 8N1 instance and an 8E2 instance, directed scenarios
// plus randomized frames checked against a frame-level reference model.
module tb_uart_rx_cfg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_tick = 1'b1;
    logic       tick_half = 1'b0;
    logic       line0 = 1'b1, line1 = 1'b1;
    logic       ready0 = 1'b0, ready1 = 1'b0;
    logic [7:0] d0, d1;
    logic       v0, pe0, fe0, ov0, b0;
    logic       v1, pe1, fe1, ov1, b1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_v0 = -1;
    int vcyc0 = 0;
    logic v0_prev = 1'b0;
    logic [7:0] acc_d0[$], acc_d1[$];
    logic [2:0] acc_f0[$], acc_f1[$];

    uart_rx_cfg dut0 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .bit_in(line0), .ready(ready0),
        .data_out(d0), .valid(v0), .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0)
    );

    uart_rx_cfg #(.PARITY(2), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .bit_in(line1), .ready(ready1),
        .data_out(d1), .valid(v1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        baud_tick = tick_half ? ~baud_tick : 1'b1;
    end

    // Capture every accepted word (valid & ready seen before the accepting edge).
    always @(negedge clk) begin
        #1;
        if (v0) vcyc0++;
        if (v0 && !v0_prev && first_v0 < 0) first_v0 = cyc;
        if (v0 && ready0) begin
            acc_d0.push_back(d0);
            acc_f0.push_back({pe0, fe0, ov0});
        end
        if (v1 && ready1) begin
            acc_d1.push_back(d1);
            acc_f1.push_back({pe1, fe1, ov1});
        end
        v0_prev = v0;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input int sel, input logic [7:0] d, input int has_par,
                              input logic pbit, input logic [1:0] stops, input int nstop,
                              input int bitclk);
        logic [15:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        n = 9;
        if (has_par != 0) begin
            bits[n] = pbit;
            n++;
        end
        for (int s = 0; s < nstop; s++) begin
            bits[n] = stops[s];
            n++;
        end
        @(negedge clk);
        if (sel == 0) start_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            if (sel == 0) line0 = bits[i];
            else line1 = bits[i];
            repeat (bitclk) @(negedge clk);
        end
        if (sel == 0) line0 = 1'b1;
        else line1 = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({v0, pe0, fe0, ov0, b0} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags0: got %b expected 00000", {v0, pe0, fe0, ov0, b0});
        end
        checks++;
        if (d0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_data0: got %h expected 00", d0);
        end
        checks++;
        if ({d1, v1, pe1, fe1, ov1, b1} !== 13'b0) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected 0", {d1, v1, pe1, fe1, ov1, b1});
        end
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({v0, b0, v1, b1} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000", {v0, b0, v1, b1});
        end
    endtask

    task automatic test_basic;
        int vc, lat, lo, hi;
        logic [7:0] gd;
        logic [2:0] gf;
        ready0 = 1'b1;
        acc_d0.delete();
        acc_f0.delete();
        vc = vcyc0;
        first_v0 = -1;
        send_frame(0, 8'hA5, 0, 1'b0, 2'b11, 1, 16);
        repeat (20) @(negedge clk);
        gd = (acc_d0.size() > 0) ? acc_d0[0] : 8'hxx;
        gf = (acc_f0.size() > 0) ? acc_f0[0] : 3'bxxx;
        checks++;
        if (acc_d0.size() != 1) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 1", acc_d0.size());
        end
        checks++;
        if (gd !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data: got %h expected a5", gd);
        end
        checks++;
        if (gf !== 3'b000) begin
            errors++;
            $display("FAIL basic_flags: got %b expected 000", gf);
        end
        checks++;
        if (vcyc0 - vc != 1) begin
            errors++;
            $display("FAIL basic_pulse: got %0d expected 1 valid cycles", vcyc0 - vc);
        end
        // Stop-bit mid decision plus synchroniser and edge-detect latency.
        lat = first_v0 - start_cyc;
        lo = 9 * 16 + 8;
        hi = lo + 8;
        checks++;
        if (lat < lo || lat > hi) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, lo, hi);
        end
        checks++;
        if (b0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 0", b0);
        end
    endtask

    task automatic test_glitch;
        int vc;
        logic seen, cleared;
        ready0 = 1'b1;
        acc_d0.delete();
        acc_f0.delete();
        vc = vcyc0;
        seen = 1'b0;
        cleared = 1'b0;
        @(negedge clk);
        line0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (b0) seen = 1'b1;
        end
        line0 = 1'b1;
        for (int i = 0; i < 12 && !cleared; i++) begin
            @(negedge clk);
            if (b0) seen = 1'b1;
            else if (seen) cleared = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_seen: got %b expected 1", seen);
        end
        checks++;
        if (cleared !== 1'b1) begin
            errors++;
            $display("FAIL glitch_busy_clear: got %b expected 1", cleared);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (vcyc0 - vc != 0 || acc_d0.size() != 0) begin
            errors++;
            $display("FAIL glitch_no_valid: got %0d expected 0", vcyc0 - vc);
        end
    endtask

    task automatic test_overrun;
        ready0 = 1'b0;
        acc_d0.delete();
        acc_f0.delete();
        send_frame(0, 8'h3C, 0, 1'b0, 2'b11, 1, 16);
        send_frame(0, 8'h81, 0, 1'b0, 2'b11, 1, 16);
        repeat (12) @(negedge clk);
        checks++;
        if ({v0, d0, pe0, fe0, ov0} !== {1'b1, 8'h81, 3'b001}) begin
            errors++;
            $display("FAIL overrun_word: got v=%b d=%h f=%b expected v=1 d=81 f=001",
                     v0, d0, {pe0, fe0, ov0});
        end
        ready0 = 1'b1;
        @(negedge clk);
        checks++;
        if (v0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drop: got %b expected 0", v0);
        end
        checks++;
        if ({d0, ov0} !== {8'h81, 1'b1}) begin
            errors++;
            $display("FAIL overrun_hold: got d=%h ov=%b expected d=81 ov=1", d0, ov0);
        end
        checks++;
        if (acc_d0.size() != 1) begin
            errors++;
            $display("FAIL overrun_accepts: got %0d expected 1", acc_d0.size());
        end
    endtask

    task automatic test_parity;
        ready1 = 1'b1;
        acc_d1.delete();
        acc_f1.delete();
        send_frame(1, 8'h07, 1, 1'b0, 2'b11, 2, 16);
        repeat (6) @(negedge clk);
        send_frame(1, 8'h07, 1, 1'b1, 2'b11, 2, 16);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_d1.size() != 2) begin
            errors++;
            $display("FAIL parity_count: got %0d expected 2", acc_d1.size());
        end
        checks++;
        if (acc_d1.size() > 0 && {acc_d1[0], acc_f1[0]} !== {8'h07, 3'b100}) begin
            errors++;
            $display("FAIL parity_bad: got d=%h f=%b expected d=07 f=100", acc_d1[0], acc_f1[0]);
        end
        checks++;
        if (acc_d1.size() > 1 && {acc_d1[1], acc_f1[1]} !== {8'h07, 3'b000}) begin
            errors++;
            $display("FAIL parity_good: got d=%h f=%b expected d=07 f=000", acc_d1[1], acc_f1[1]);
        end
    endtask

    task automatic test_break;
        ready0 = 1'b1;
        acc_d0.delete();
        acc_f0.delete();
        @(negedge clk);
        line0 = 1'b0;
        repeat (40 * 16) @(negedge clk);
        checks++;
        if (b0 !== 1'b1) begin
            errors++;
            $display("FAIL break_busy: got %b expected 1", b0);
        end
        checks++;
        if (acc_d0.size() != 1) begin
            errors++;
            $display("FAIL break_count: got %0d expected 1", acc_d0.size());
        end
        checks++;
        if (acc_d0.size() > 0 && {acc_d0[0], acc_f0[0]} !== {8'h00, 3'b010}) begin
            errors++;
            $display("FAIL break_word: got d=%h f=%b expected d=00 f=010", acc_d0[0], acc_f0[0]);
        end
        line0 = 1'b1;
        repeat (32) @(negedge clk);
        checks++;
        if (b0 !== 1'b0) begin
            errors++;
            $display("FAIL break_exit: got %b expected 0", b0);
        end
        send_frame(0, 8'h55, 0, 1'b0, 2'b11, 1, 16);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_d0.size() != 2 || {acc_d0[1], acc_f0[1]} !== {8'h55, 3'b000}) begin
            errors++;
            $display("FAIL break_next: got n=%0d d=%h expected n=2 d=55 f=000",
                     acc_d0.size(), acc_d0[acc_d0.size()-1]);
        end
    endtask

    task automatic test_reset_midframe;
        ready0 = 1'b0;
        acc_d0.delete();
        acc_f0.delete();
        send_frame(0, 8'h3C, 0, 1'b0, 2'b11, 1, 16);
        repeat (10) @(negedge clk);
        line0 = 1'b0;
        repeat (16) @(negedge clk);
        line0 = 1'b1;
        repeat (16 * 4 + 8) @(negedge clk);
        checks++;
        if ({v0, b0} !== 2'b11) begin
            errors++;
            $display("FAIL midframe_pre: got %b expected 11", {v0, b0});
        end
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({d0, v0, pe0, fe0, ov0, b0} !== 13'b0) begin
            errors++;
            $display("FAIL midframe_reset: got %h expected 0", {d0, v0, pe0, fe0, ov0, b0});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (32) @(negedge clk);
        ready0 = 1'b1;
        send_frame(0, 8'h12, 0, 1'b0, 2'b11, 1, 16);
        repeat (20) @(negedge clk);
        checks++;
        if (acc_d0.size() != 1 || {acc_d0[0], acc_f0[0]} !== {8'h12, 3'b000}) begin
            errors++;
            $display("FAIL midframe_next: got n=%0d expected n=1 d=12 f=000", acc_d0.size());
        end
    endtask

    task automatic test_tick;
        int vc;
        ready0 = 1'b1;
        acc_d0.delete();
        acc_f0.delete();
        tick_half = 1'b1;
        repeat (4) @(negedge clk);
        vc = vcyc0;
        send_frame(0, 8'hC3, 0, 1'b0, 2'b11, 1, 32);
        repeat (40) @(negedge clk);
        checks++;
        if (acc_d0.size() != 1 || {acc_d0[0], acc_f0[0]} !== {8'hC3, 3'b000}) begin
            errors++;
            $display("FAIL tick_word: got n=%0d expected n=1 d=c3 f=000", acc_d0.size());
        end
        checks++;
        if (vcyc0 - vc != 1) begin
            errors++;
            $display("FAIL tick_pulse: got %0d expected 1 valid cycles", vcyc0 - vc);
        end
        tick_half = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random;
        logic [7:0] exp_d0[$], exp_d1[$];
        logic [2:0] exp_f1[$];
        logic [7:0] d, gd;
        logic [2:0] gf;
        logic       p;
        logic [1:0] st;
        ready0 = 1'b1;
        ready1 = 1'b1;
        acc_d0.delete();
        acc_f0.delete();
        acc_d1.delete();
        acc_f1.delete();
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom_range(0, 255));
            exp_d0.push_back(d);
            send_frame(0, d, 0, 1'b0, 2'b11, 1, 16);
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            st = 2'($urandom_range(0, 3));
            exp_d1.push_back(d);
            // Even parity: the parity bit should equal the XOR of the data bits.
            exp_f1.push_back({p ^ (^d), ~(st[0] & st[1]), 1'b0});
            send_frame(1, d, 1, p, st, 2, 16);
            repeat ($urandom_range(4, 30)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (acc_d0.size() != exp_d0.size() || acc_d1.size() != exp_d1.size()) begin
            errors++;
            $display("FAIL random_count: got %0d/%0d expected %0d/%0d",
                     acc_d0.size(), acc_d1.size(), exp_d0.size(), exp_d1.size());
        end
        for (int k = 0; k < exp_d0.size(); k++) begin
            gd = (k < acc_d0.size()) ? acc_d0[k] : 8'hxx;
            gf = (k < acc_f0.size()) ? acc_f0[k] : 3'bxxx;
            checks++;
            if ({gd, gf} !== {exp_d0[k], 3'b000}) begin
                errors++;
                $display("FAIL random8n1_%0d: got d=%h f=%b expected d=%h f=000",
                         k, gd, gf, exp_d0[k]);
            end
        end
        for (int k = 0; k < exp_d1.size(); k++) begin
            gd = (k < acc_d1.size()) ? acc_d1[k] : 8'hxx;
            gf = (k < acc_f1.size()) ? acc_f1[k] : 3'bxxx;
            checks++;
            if ({gd, gf} !== {exp_d1[k], exp_f1[k]}) begin
                errors++;
                $display("FAIL random8e2_%0d: got d=%h f=%b expected d=%h f=%b",
                         k, gd, gf, exp_d1[k], exp_f1[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_overrun();
        test_parity();
        test_break();
        test_reset_midframe();
        test_tick();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
